// File: rtl/pmod_da2_scheduler.sv
// pmod_da2_scheduler
// Sample-rate scheduler for a two-channel DAC121S101 serializer (PMOD DA2).
// Two stream requesters fill small per-channel FIFOs. Each sample period the
// scheduler pops one sample per channel and builds the two 16-bit DAC words.
// It then requests one serializer frame through a start/busy handshake.
//
// Ports
//   CLK_i, ARESETN_i        clock, synchronous active-low reset
//   ENABLE_i                scheduling on/off (FIFOs keep accepting when off)
//   PERIOD_i                sample period in clocks (values below 2 act as 2)
//   PD_MODE_i               DAC power-down bits placed in both words
//   S0_/S1_TDATA/TVALID_i   per-channel 12-bit sample streams
//   S0_/S1_TREADY_o         per-channel FIFO not full
//   DAC_DATA0_o/1_o         {2'b00, PD, sample} words for DIN0/DIN1
//   DAC_START_o             one-cycle serializer request
//   DAC_BUSY_i              serializer busy
//   UNDERRUN0_o/1_o         saturating count of ticks that found a FIFO empty
//   MISSED_o                sticky: a tick arrived while a frame was in flight
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a sample tick
// LOAD     | pop FIFOs (or count underrun) and update the DAC words
// START    | request a frame as soon as the serializer is not busy
// WAIT_HI  | wait up to 2 cycles for busy to rise
// WAIT_LO  | wait for busy to fall (frame end)
module pmod_da2_scheduler #(
  parameter int FIFO_AW  = 2,
  parameter int PERIOD_W = 16
) (
  input  logic                CLK_i,
  input  logic                ARESETN_i,
  input  logic                ENABLE_i,
  input  logic [PERIOD_W-1:0] PERIOD_i,
  input  logic [1:0]          PD_MODE_i,
  input  logic [11:0]         S0_TDATA_i,
  input  logic                S0_TVALID_i,
  output logic                S0_TREADY_o,
  input  logic [11:0]         S1_TDATA_i,
  input  logic                S1_TVALID_i,
  output logic                S1_TREADY_o,
  output logic [15:0]         DAC_DATA0_o,
  output logic [15:0]         DAC_DATA1_o,
  output logic                DAC_START_o,
  input  logic                DAC_BUSY_i,
  output logic [7:0]          UNDERRUN0_o,
  output logic [7:0]          UNDERRUN1_o,
  output logic                MISSED_o
);

  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT_HI,
    ST_WAIT_LO
  } state_t;

  state_t state, state_nxt;

  // ---------------------------------------------------------------------
  // Sample-period counter
  // ---------------------------------------------------------------------
  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] per_lat;
  logic [PERIOD_W-1:0] per_in;
  logic [PERIOD_W-1:0] per_eff;
  logic                tick;

  // The period is taken from PERIOD_i only while the count sits at 0, so a
  // change made mid-count is applied after the current wrap.
  always_comb begin
    per_in  = (PERIOD_i < PERIOD_W'(2)) ? PERIOD_W'(2) : PERIOD_i;
    per_eff = (cnt == '0) ? per_in : per_lat;
  end

  assign tick = ENABLE_i && (cnt == per_eff - PERIOD_W'(1));

  always_ff @(posedge CLK_i) begin
    if (!ARESETN_i) begin
      cnt     <= '0;
      per_lat <= PERIOD_W'(2);
    end else begin
      per_lat <= per_eff;
      if (!ENABLE_i || (cnt == per_eff - PERIOD_W'(1))) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + PERIOD_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Per-channel FIFOs
  // ---------------------------------------------------------------------
  logic [1:0]       s_valid;
  logic [1:0][11:0] s_data;
  logic [1:0]       fifo_ready;
  logic [1:0]       fifo_empty;
  logic [1:0][11:0] fifo_head;

  assign s_valid = {S1_TVALID_i, S0_TVALID_i};
  assign s_data  = {S1_TDATA_i, S0_TDATA_i};

  for (genvar gc = 0; gc < 2; gc++) begin : g_fifo
    logic [11:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   occ;
    logic [FIFO_AW:0]   occ_nxt;
    logic               rdy;
    logic               push;
    logic               pop;

    assign push = s_valid[gc] && rdy;
    assign pop  = (state == ST_LOAD) && (occ != '0);

    assign fifo_ready[gc] = rdy;
    assign fifo_empty[gc] = (occ == '0);
    assign fifo_head[gc]  = mem[rd_ptr];

    always_comb begin
      occ_nxt = occ;
      case ({push, pop})
        2'b10:   occ_nxt = occ + (FIFO_AW+1)'(1);
        2'b01:   occ_nxt = occ - (FIFO_AW+1)'(1);
        default: occ_nxt = occ;
      endcase
    end

    // Ready is registered from the next occupancy so it never depends
    // combinationally on TVALID.
    always_ff @(posedge CLK_i) begin
      if (!ARESETN_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        occ    <= '0;
        rdy    <= 1'b1;
      end else begin
        if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
        if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
        occ <= occ_nxt;
        rdy <= (occ_nxt != (FIFO_AW+1)'(DEPTH));
      end
    end

    always_ff @(posedge CLK_i) begin
      if (push) mem[wr_ptr] <= s_data[gc];
    end
  end

  assign S0_TREADY_o = fifo_ready[0];
  assign S1_TREADY_o = fifo_ready[1];

  // ---------------------------------------------------------------------
  // Sequencing FSM
  // ---------------------------------------------------------------------
  logic wait_cnt;
  logic dac_start;

  always_ff @(posedge CLK_i) begin
    if (!ARESETN_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    dac_start = 1'b0;
    case (state)
      ST_IDLE: begin
        if (tick) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        state_nxt = ST_START;
      end
      ST_START: begin
        if (!DAC_BUSY_i) begin
          dac_start = 1'b1;
          state_nxt = ST_WAIT_HI;
        end
      end
      ST_WAIT_HI: begin
        if (DAC_BUSY_i) begin
          state_nxt = ST_WAIT_LO;
        end else if (wait_cnt == 1'b0) begin
          // Busy never showed up; treat the frame as already finished.
          state_nxt = ST_IDLE;
        end
      end
      ST_WAIT_LO: begin
        if (!DAC_BUSY_i) state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Down-counter covering the two WAIT_HI cycles; loaded while in START.
  always_ff @(posedge CLK_i) begin
    if (!ARESETN_i) begin
      wait_cnt <= 1'b0;
    end else if (state == ST_START) begin
      wait_cnt <= 1'b1;
    end else if ((state == ST_WAIT_HI) && (wait_cnt != 1'b0)) begin
      wait_cnt <= 1'b0;
    end
  end

  assign DAC_START_o = dac_start;

  // ---------------------------------------------------------------------
  // DAC words, underrun counters, missed-tick flag
  // ---------------------------------------------------------------------
  logic [15:0] dac_data0;
  logic [15:0] dac_data1;
  logic [7:0]  underrun0;
  logic [7:0]  underrun1;
  logic        missed;

  always_ff @(posedge CLK_i) begin
    if (!ARESETN_i) begin
      dac_data0 <= '0;
      dac_data1 <= '0;
      underrun0 <= '0;
      underrun1 <= '0;
      missed    <= 1'b0;
    end else begin
      if (tick && (state != ST_IDLE)) missed <= 1'b1;

      if (state == ST_LOAD) begin
        // An empty FIFO repeats the previous sample but still picks up
        // the current power-down bits.
        dac_data0 <= {2'b00, PD_MODE_i,
                      fifo_empty[0] ? dac_data0[11:0] : fifo_head[0]};
        dac_data1 <= {2'b00, PD_MODE_i,
                      fifo_empty[1] ? dac_data1[11:0] : fifo_head[1]};
        if (fifo_empty[0] && (underrun0 != 8'hFF)) underrun0 <= underrun0 + 8'd1;
        if (fifo_empty[1] && (underrun1 != 8'hFF)) underrun1 <= underrun1 + 8'd1;
      end
    end
  end

  assign DAC_DATA0_o = dac_data0;
  assign DAC_DATA1_o = dac_data1;
  assign UNDERRUN0_o = underrun0;
  assign UNDERRUN1_o = underrun1;
  assign MISSED_o    = missed;

endmodule

// File: doc/pmod_da2_scheduler.md
Name: pmod_da2_scheduler

Overview:
Sample-rate scheduler and data sequencer for the two-channel DAC121S101 serializer (PMOD DA2). It buffers 12-bit samples from two independent stream requesters in small per-channel FIFOs. At a programmable sample period it pops one sample per channel and formats two 16-bit DAC words. It then launches a single serializer transfer with a start/busy handshake and reports underruns and missed ticks.

Parameters:
FIFO_AW, 2, log2 of per-channel FIFO depth (depth 4).
PERIOD_W, 16, width of the sample-period counter.

Ports:
CLK_i  in  1  system clock; all logic is on this clock.
ARESETN_i  in  1  synchronous active-low reset.
ENABLE_i  in  1  1 = scheduling active; 0 = ticks ignored, FIFOs still accept data.
PERIOD_i  in  PERIOD_W  sample period in CLK_i cycles; values below 2 are treated as 2.
PD_MODE_i  in  2  DAC power-down bits PD1:PD0, inserted into both words.
S0_TDATA_i  in  12  channel-0 sample.
S0_TVALID_i  in  1  channel-0 sample valid.
S0_TREADY_o  out  1  channel-0 FIFO not full.
S1_TDATA_i  in  12  channel-1 sample.
S1_TVALID_i  in  1  channel-1 sample valid.
S1_TREADY_o  out  1  channel-1 FIFO not full.
DAC_DATA0_o  out  16  word for DIN0 = {2'b00, PD_MODE, sample0}.
DAC_DATA1_o  out  16  word for DIN1 = {2'b00, PD_MODE, sample1}.
DAC_START_o  out  1  one-cycle transfer request to the serializer.
DAC_BUSY_i  in  1  serializer busy; rises within 2 cycles of START and falls at frame end.
UNDERRUN0_o  out  8  saturating count of ticks that found FIFO0 empty.
UNDERRUN1_o  out  8  saturating count of ticks that found FIFO1 empty.
MISSED_o  out  1  sticky flag: a tick arrived while a transfer was still in progress.

Behaviour:
- Reset values:
  - FIFOs are empty.
  - S*_TREADY_o = 1 from the first cycle after reset.
  - DAC_DATA*_o = 16'h0000.
  - DAC_START_o = 0.
  - UNDERRUN*_o = 0.
  - MISSED_o = 0.
  - Period counter = 0.
  - FSM is in IDLE.
- Reset mid-transfer aborts the FSM to IDLE. No START is issued until the first post-reset tick.
- FIFOs:
  - Push when TVALID & TREADY.
  - TREADY = !full, registered from occupancy.
  - On a simultaneous push and pop, occupancy is unchanged.
  - Pointers wrap modulo depth.
- Period counter:
  - Counts 0..P-1, where P = max(PERIOD_i, 2), sampled at wrap.
  - tick = (count == P-1) & ENABLE_i.
  - When ENABLE_i = 0, the counter is held at 0.
  - A PERIOD_i change takes effect at the next wrap.
- FSM states:
  - IDLE: on tick go to LOAD.
  - LOAD (1 cycle):
    - Per channel, pop a non-empty FIFO and latch its sample into DAC_DATAx_o.
    - If the FIFO is empty, keep the previous 12-bit sample, refresh the PD bits, and increment UNDERRUNx_o (saturates at 255).
    - Go to START.
  - START: when DAC_BUSY_i = 0, assert DAC_START_o for exactly 1 cycle and go to WAIT_HI. Otherwise stay in START.
  - WAIT_HI: wait for DAC_BUSY_i = 1, then go to WAIT_LO. If busy has not risen after 2 cycles, go to IDLE (transfer assumed complete).
  - WAIT_LO: when DAC_BUSY_i = 0, go to IDLE.
- Latency: tick to DAC_START_o is 2 cycles when the serializer is idle.
- A tick in any state other than IDLE sets MISSED_o. The tick is dropped, not queued. MISSED_o clears only on reset.
- DAC_DATA*_o are stable from LOAD until the next LOAD.

Test Plan:
- Reset, then PERIOD_i=10, ENABLE_i=1, push 0x123 on ch0 and 0x456 on ch1, PD_MODE=0, busy model 5 cycles -> START exactly every 10 cycles; DAC_DATA0_o=16'h0123, DAC_DATA1_o=16'h0456 at the first START; UNDERRUN*=0.
- No pushes, PERIOD_i=8, 300 ticks -> DAC_DATA* hold 0x0000; UNDERRUN0/1 saturate at 255 and do not wrap.
- Push 5 samples on ch0 with ENABLE_i=0 -> TREADY drops after 4 accepted pushes; the 5th waits. After enable, samples are output in FIFO order.
- PERIOD_i=4, busy model held high for 12 cycles -> MISSED_o=1, one START per completed frame, no START while busy.
- PERIOD_i=0 or 1 -> ticks every 2 cycles. Change PERIOD_i 10->20 mid-count -> the new spacing is applied only after the current wrap.
- Assert ARESETN_i=0 during WAIT_LO, then release -> all outputs return to reset values; the next START follows the first tick.
